// File: rtl/prio_task_heap.sv
// prio_task_heap: min-heap task scheduler. Presents the entry with the smallest priority value
// at the root. Push, pop and replace-top are multi-cycle sift operations; busy_o stalls the
// pipeline while a sift is in progress.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-low reset
//   flush_i               synchronous clear, overrides op_i and any sift in progress
//   op_i                  00 none, 01 push, 10 pop, 11 replace-top
//   prio_i, ctx_addr_i    entry written by push/replace
//   busy_o                sift in progress, op_i ignored
//   top_valid_o           root is valid and stable
//   top_prio_o/top_ctx_o  root entry (hold last value while empty)
//   count_o, full_o, empty_o  occupancy
//   err_o                 one-cycle pulse: 01 overflow, 10 underflow
//
// Optional build macro PRIO_TASK_HEAP_FIFO_TIEBREAK_EN: adds a 16-bit arrival stamp to every
// entry so equal priorities leave in arrival order (wrap-aware compare).
module prio_task_heap #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned PRIO_W = 8,
   parameter int unsigned ADDR_W = 32
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     flush_i,
   input  logic [1:0]               op_i,
   input  logic [PRIO_W-1:0]        prio_i,
   input  logic [ADDR_W-1:0]        ctx_addr_i,
   output logic                     busy_o,
   output logic                     top_valid_o,
   output logic [PRIO_W-1:0]        top_prio_o,
   output logic [ADDR_W-1:0]        top_ctx_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [1:0]               err_o
);

   localparam int unsigned IW = $clog2(DEPTH);
   localparam int unsigned CW = IW + 1;
   localparam int unsigned XW = IW + 2;  // wide enough for child indices 2i+2

   localparam logic [1:0] OpPush    = 2'b01;
   localparam logic [1:0] OpPop     = 2'b10;
   localparam logic [1:0] OpReplace = 2'b11;

   typedef enum logic [1:0] {StIdle, StSiftUp, StSiftDown} state_e;

   typedef struct packed {
      logic [PRIO_W-1:0] prio;
`ifdef PRIO_TASK_HEAP_FIFO_TIEBREAK_EN
      logic [15:0]       stamp;
`endif
      logic [ADDR_W-1:0] ctx;
   } entry_t;

`ifdef PRIO_TASK_HEAP_FIFO_TIEBREAK_EN
   // a is older than b when (a - b) is negative in 16-bit modular arithmetic.
   function automatic logic key_lt(input entry_t a, input entry_t b);
      logic [15:0] diff;
      diff = a.stamp - b.stamp;
      return (a.prio < b.prio) || ((a.prio == b.prio) && diff[15]);
   endfunction
`else
   function automatic logic key_lt(input entry_t a, input entry_t b);
      return a.prio < b.prio;
   endfunction
`endif

   entry_t            ent_q [DEPTH];
   entry_t            ent_d [DEPTH];
   entry_t            new_ent;
   state_e            state_q, state_d;
   logic [CW-1:0]     count_q, count_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [1:0]        err_q, err_d;
   logic [PRIO_W-1:0] top_prio_q;
   logic [ADDR_W-1:0] top_ctx_q;
`ifdef PRIO_TASK_HEAP_FIFO_TIEBREAK_EN
   logic [15:0]       stamp_q, stamp_d;
`endif

   // Sift helpers
   logic [IW-1:0] parent_idx, last_idx, l_idx, r_idx, cand_idx, sel_idx;
   logic [XW-1:0] l_full, r_full, cnt_x;
   logic          l_ok, r_ok, lt_up, sel_has_child;

   always_comb begin
      new_ent.prio  = prio_i;
      new_ent.ctx   = ctx_addr_i;
`ifdef PRIO_TASK_HEAP_FIFO_TIEBREAK_EN
      new_ent.stamp = stamp_q;
`endif
      parent_idx    = (idx_q - IW'(1)) >> 1;
      last_idx      = IW'(count_q - CW'(1));
      cnt_x         = XW'(count_q);
      l_full        = {1'b0, idx_q, 1'b1};
      r_full        = l_full + XW'(1);
      l_ok          = l_full < cnt_x;
      r_ok          = r_full < cnt_x;
      l_idx         = IW'(l_full);
      r_idx         = IW'(r_full);
      lt_up         = key_lt(ent_q[idx_q], ent_q[parent_idx]);
      // Right child must be strictly smaller than the left winner, so ties favour the left.
      cand_idx      = (l_ok && key_lt(ent_q[l_idx], ent_q[idx_q])) ? l_idx : idx_q;
      sel_idx       = (r_ok && key_lt(ent_q[r_idx], ent_q[cand_idx])) ? r_idx : cand_idx;
      sel_has_child = XW'({1'b0, sel_idx, 1'b1}) < cnt_x;
   end

   always_comb begin
      ent_d   = ent_q;
      count_d = count_q;
      idx_d   = idx_q;
      state_d = state_q;
      err_d   = 2'b00;
`ifdef PRIO_TASK_HEAP_FIFO_TIEBREAK_EN
      stamp_d = stamp_q;
`endif
      if (flush_i) begin
         count_d = '0;
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (op_i == OpPush || (op_i == OpReplace && count_q == '0)) begin
                  if (count_q == CW'(DEPTH)) begin
                     err_d = 2'b01;
                  end else begin
                     ent_d[count_q[IW-1:0]] = new_ent;
                     count_d = count_q + CW'(1);
                     idx_d   = count_q[IW-1:0];
                     if (count_q != '0) state_d = StSiftUp;
`ifdef PRIO_TASK_HEAP_FIFO_TIEBREAK_EN
                     stamp_d = stamp_q + 16'd1;
`endif
                  end
               end else if (op_i == OpPop) begin
                  if (count_q == '0) begin
                     err_d = 2'b10;
                  end else begin
                     ent_d[0] = ent_q[last_idx];
                     count_d  = count_q - CW'(1);
                     idx_d    = '0;
                     if (count_q > CW'(2)) state_d = StSiftDown;
                  end
               end else if (op_i == OpReplace) begin
                  ent_d[0] = new_ent;
                  idx_d    = '0;
                  if (count_q > CW'(1)) state_d = StSiftDown;
`ifdef PRIO_TASK_HEAP_FIFO_TIEBREAK_EN
                  stamp_d = stamp_q + 16'd1;
`endif
               end
            end
            StSiftUp: begin
               if (lt_up) begin
                  ent_d[idx_q]      = ent_q[parent_idx];
                  ent_d[parent_idx] = ent_q[idx_q];
                  idx_d             = parent_idx;
                  if (parent_idx == '0) state_d = StIdle;
               end else begin
                  state_d = StIdle;
               end
            end
            StSiftDown: begin
               if (sel_idx != idx_q) begin
                  ent_d[idx_q]   = ent_q[sel_idx];
                  ent_d[sel_idx] = ent_q[idx_q];
                  idx_d          = sel_idx;
                  // Stop as soon as the moved entry lands on a leaf.
                  if (!sel_has_child) state_d = StIdle;
               end else begin
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // Entry storage carries no reset; contents are meaningless beyond count_q.
   always_ff @(posedge clk_i) begin
      ent_q <= ent_d;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= StIdle;
         count_q    <= '0;
         idx_q      <= '0;
         err_q      <= 2'b00;
         top_prio_q <= '0;
         top_ctx_q  <= '0;
`ifdef PRIO_TASK_HEAP_FIFO_TIEBREAK_EN
         stamp_q    <= '0;
`endif
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         idx_q      <= idx_d;
         err_q      <= err_d;
         top_prio_q <= ent_d[0].prio;
         top_ctx_q  <= ent_d[0].ctx;
`ifdef PRIO_TASK_HEAP_FIFO_TIEBREAK_EN
         stamp_q    <= stamp_d;
`endif
      end
   end

   assign busy_o      = state_q != StIdle;
   assign empty_o     = count_q == '0;
   assign full_o      = count_q == CW'(DEPTH);
   assign top_valid_o = !empty_o && !busy_o;
   assign top_prio_o  = top_prio_q;
   assign top_ctx_o   = top_ctx_q;
   assign count_o     = count_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_prio_task_heap.sv
// Directed self-checking bench for prio_task_heap (DEPTH=16, PRIO_W=8, ADDR_W=32).
module tb_prio_task_heap;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        flush_i = 1'b0;
   logic [1:0]  op_i = 2'b00;
   logic [7:0]  prio_i = '0;
   logic [31:0] ctx_addr_i = '0;
   logic        busy_o, top_valid_o, full_o, empty_o;
   logic [7:0]  top_prio_o;
   logic [31:0] top_ctx_o;
   logic [4:0]  count_o;
   logic [1:0]  err_o;

   int n_total = 0;
   int n_bad   = 0;

   prio_task_heap #(.DEPTH(16), .PRIO_W(8), .ADDR_W(32)) u_dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .flush_i     (flush_i),
      .op_i        (op_i),
      .prio_i      (prio_i),
      .ctx_addr_i  (ctx_addr_i),
      .busy_o      (busy_o),
      .top_valid_o (top_valid_o),
      .top_prio_o  (top_prio_o),
      .top_ctx_o   (top_ctx_o),
      .count_o     (count_o),
      .full_o      (full_o),
      .empty_o     (empty_o),
      .err_o       (err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Present op for exactly one rising edge; returns at the negedge after it.
   task automatic issue(input logic [1:0] op, input logic [7:0] p, input logic [31:0] c);
      @(negedge clk_i);
      op_i = op; prio_i = p; ctx_addr_i = c;
      @(negedge clk_i);
      op_i = 2'b00;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy_o && n < 40) begin
         @(negedge clk_i);
         n++;
      end
      if (busy_o) check("idle_timeout", 64'(busy_o), 64'd0);
   endtask

   task automatic push(input logic [7:0] p, input logic [31:0] c);
      issue(2'b01, p, c);
      wait_idle();
   endtask

   task automatic pop_chk(input string tag, input logic [7:0] p, input logic [31:0] c);
      check({tag, "_valid"}, 64'(top_valid_o), 64'd1);
      check({tag, "_prio"}, 64'(top_prio_o), 64'(p));
      check({tag, "_ctx"}, 64'(top_ctx_o), 64'(c));
      issue(2'b10, 8'h0, 32'h0);
      wait_idle();
   endtask

   task automatic flush();
      @(negedge clk_i);
      flush_i = 1'b1;
      @(negedge clk_i);
      flush_i = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_busy"}, 64'(busy_o), 64'd0);
      check({tag, "_valid"}, 64'(top_valid_o), 64'd0);
      check({tag, "_prio"}, 64'(top_prio_o), 64'd0);
      check({tag, "_ctx"}, 64'(top_ctx_o), 64'd0);
      check({tag, "_count"}, 64'(count_o), 64'd0);
      check({tag, "_err"}, 64'(err_o), 64'd0);
      check({tag, "_empty"}, 64'(empty_o), 64'd1);
      check({tag, "_full"}, 64'(full_o), 64'd0);
   endtask

   initial begin
      int n;
      repeat (2) @(negedge clk_i);
      check_reset_vals("reset");
      rst_i = 1'b1;

      // Basic ordering
      push(8'd5, 32'h100);
      push(8'd3, 32'h200);
      push(8'd8, 32'h300);
      push(8'd1, 32'h400);
      check("push4_count", 64'(count_o), 64'd4);
      pop_chk("pop1", 8'd1, 32'h400);
      pop_chk("pop2", 8'd3, 32'h200);
      pop_chk("pop3", 8'd5, 32'h100);
      pop_chk("pop4", 8'd8, 32'h300);
      check("drained_empty", 64'(empty_o), 64'd1);

      // Sift-up of 1 into {3,5,8} climbs two levels
      push(8'd5, 32'h100);
      push(8'd3, 32'h200);
      push(8'd8, 32'h300);
      issue(2'b01, 8'd1, 32'h400);
      n = 0;
      while (busy_o && n < 20) begin
         n++;
         @(negedge clk_i);
      end
      check("push_busy_cycles", 64'(n), 64'd2);
      check("sift_top_prio", 64'(top_prio_o), 64'd1);
      flush();

      // Overflow
      for (int i = 0; i < 16; i++) push(8'(20 + i), 32'(i));
      check("fill_count", 64'(count_o), 64'd16);
      check("fill_full", 64'(full_o), 64'd1);
      issue(2'b01, 8'd1, 32'hDEAD);
      check("ovf_err", 64'(err_o), 64'd1);
      check("ovf_busy", 64'(busy_o), 64'd0);
      @(negedge clk_i);
      check("ovf_err_clear", 64'(err_o), 64'd0);
      check("ovf_count", 64'(count_o), 64'd16);
      check("ovf_full", 64'(full_o), 64'd1);
      check("ovf_top_prio", 64'(top_prio_o), 64'd20);
      check("ovf_top_ctx", 64'(top_ctx_o), 64'd0);
      flush();
      check("flush_empty", 64'(empty_o), 64'd1);

      // Underflow, then replace on empty acts as push
      issue(2'b10, 8'h0, 32'h0);
      check("udf_err", 64'(err_o), 64'd2);
      check("udf_empty", 64'(empty_o), 64'd1);
      @(negedge clk_i);
      check("udf_err_clear", 64'(err_o), 64'd0);
      issue(2'b11, 8'd7, 32'hA0);
      check("rep_empty_err", 64'(err_o), 64'd0);
      wait_idle();
      check("rep_empty_count", 64'(count_o), 64'd1);
      check("rep_empty_prio", 64'(top_prio_o), 64'd7);
      check("rep_empty_ctx", 64'(top_ctx_o), 64'hA0);
      flush();

      // Replace-top with sift-down
      push(8'd2, 32'h2);
      push(8'd4, 32'h4);
      push(8'd6, 32'h6);
      issue(2'b11, 8'd9, 32'h9);
      wait_idle();
      check("rep_count", 64'(count_o), 64'd3);
      pop_chk("rep_pop1", 8'd4, 32'h4);
      pop_chk("rep_pop2", 8'd6, 32'h6);
      pop_chk("rep_pop3", 8'd9, 32'h9);

      // Flush during sift-up
      for (int k = 1; k <= 7; k++) push(8'(10 * k), 32'(k));
      issue(2'b01, 8'd1, 32'h77);
      check("flush_sift_busy", 64'(busy_o), 64'd1);
      flush_i = 1'b1;
      @(negedge clk_i);
      flush_i = 1'b0;
      check("flush_sift_count", 64'(count_o), 64'd0);
      check("flush_sift_busy_clr", 64'(busy_o), 64'd0);
      check("flush_sift_empty", 64'(empty_o), 64'd1);
      check("flush_sift_valid", 64'(top_valid_o), 64'd0);

      // Reset during sift-up
      for (int k = 1; k <= 7; k++) push(8'(10 * k), 32'(k));
      issue(2'b01, 8'd1, 32'h77);
      check("rst_sift_busy", 64'(busy_o), 64'd1);
      rst_i = 1'b0;
      #1;
      check_reset_vals("rst_sift");
      @(negedge clk_i);
      rst_i = 1'b1;

`ifdef PRIO_TASK_HEAP_FIFO_TIEBREAK_EN
      push(8'd3, 32'h10);
      push(8'd3, 32'h20);
      push(8'd3, 32'h30);
      pop_chk("fifo1", 8'd3, 32'h10);
      pop_chk("fifo2", 8'd3, 32'h20);
      pop_chk("fifo3", 8'd3, 32'h30);
      // Restart stamps at 0, then advance to 0xFFFE with back-to-back single-entry replaces.
      @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b1;
      push(8'd3, 32'h1);
      @(negedge clk_i);
      op_i = 2'b11; prio_i = 8'd3; ctx_addr_i = 32'h1;
      repeat (65533) @(negedge clk_i);
      op_i = 2'b00;
      issue(2'b10, 8'h0, 32'h0);
      wait_idle();
      push(8'd3, 32'h10);
      push(8'd3, 32'h20);
      push(8'd3, 32'h30);
      pop_chk("wrap1", 8'd3, 32'h10);
      pop_chk("wrap2", 8'd3, 32'h20);
      pop_chk("wrap3", 8'd3, 32'h30);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/prio_task_heap.md
Name: prio_task_heap

Overview:
- Parametrised hardware min-heap task scheduler; the next generation of the core's fixed heap block.
- Holds up to DEPTH {priority, context-address} entries and always presents the highest-priority task (smallest priority value) to the CSR/pipeline-control side.
- Insert and extract run as multi-cycle sift state machines; busy_o drives a pipeline stall.
- Adds replace-top, flush, configurable depth and widths, and optional FIFO ordering among equal priorities.

Parameters:
- DEPTH, 16, max entries; power of two, 2..256.
- PRIO_W, 8, priority width; smaller value = higher priority.
- ADDR_W, 32, context memory address width (XLEN).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous clear of the heap; highest priority.
- op_i  in  2  00 none, 01 push, 10 pop, 11 replace-top (pop + push in one operation).
- prio_i  in  PRIO_W  priority for push/replace.
- ctx_addr_i  in  ADDR_W  context address for push/replace.
- busy_o  out  1  FSM not idle; op_i is ignored; drives pipeline stall.
- top_valid_o  out  1  !empty_o && !busy_o.
- top_prio_o  out  PRIO_W  root priority.
- top_ctx_o  out  ADDR_W  root context address.
- count_o  out  $clog2(DEPTH)+1  occupancy.
- full_o  out  1  count_o == DEPTH.
- empty_o  out  1  count_o == 0.
- err_o  out  2  one-cycle pulse: 01 overflow, 10 underflow; otherwise 00.

Behaviour:
- Reset (async, rst_i=0): count 0, FSM IDLE; busy_o 0, top_valid_o 0, top_prio_o 0, top_ctx_o 0, err_o 00, empty_o 1, full_o 0.
- Storage is a register array indexed 0..DEPTH-1. Parent of i is (i-1)>>1; children are 2i+1 and 2i+2. Only indices below count are valid.
- FSM states are IDLE, SIFT_UP and SIFT_DOWN. An op is accepted only in IDLE with busy_o=0.
- Push, not full:
  - entry[count] <= new; count++; idx <= old count.
  - Next state SIFT_UP if old count != 0, else IDLE.
- Push, full: no state change; err_o=01 on the next cycle.
- Pop, not empty:
  - entry[0] <= entry[count-1]; count--; idx <= 0.
  - Next state SIFT_DOWN if the new count > 1, else IDLE.
- Pop, empty: no change; err_o=10.
- Replace, not empty: entry[0] <= new; count unchanged; SIFT_DOWN if count > 1. Replace on an empty heap behaves exactly as push; no error.
- SIFT_UP, one level per cycle:
  - If key(idx) < key(parent): swap and set idx <= parent.
  - Return to IDLE when no swap occurs, or when the swap reaches index 0.
- SIFT_DOWN, one level per cycle:
  - Select the smallest key among idx and its valid children.
  - If a child is smaller: swap and set idx <= that child; otherwise IDLE.
  - Return to IDLE also when idx has no valid child.
- Comparison is strict less-than; on a tie with a left child, the left child is chosen.
- Latency: busy_o rises the cycle after acceptance. Worst case is $clog2(DEPTH) sift cycles. Tops are registered from entry[0] and are correct once busy_o=0.
- flush_i=1: count <= 0, FSM <= IDLE, err_o <= 00. Any in-progress sift is aborted. op_i in the same cycle is ignored.
- Reset mid-sift: everything returns to its reset values; entry contents are don't-care.
- top_ctx_o/top_prio_o hold their last root value while empty; consumers must qualify them with top_valid_o.

Optional Feature:
- Macro: PRIO_TASK_HEAP_FIFO_TIEBREAK_EN.
- Defined:
  - Each entry carries a 16-bit sequence stamp taken from a global counter that increments on every accepted push or replace.
  - The key is {prio, stamp}. Stamps compare wrap-aware: a older than b iff (a-b)[15]=1.
  - Equal priorities therefore leave in arrival order.
  - The counter resets to 0 and is not cleared by flush_i.
- Undefined: no stamp storage; ties are resolved by the strict-compare rules above, and arrival order is not guaranteed.

Test Plan:
- DEPTH=16: push prio 5,3,8,1 (ctx 0x100,0x200,0x300,0x400), waiting !busy_o between pushes -> top 1/0x400, count 4. Pop x4 yields prio 1,3,5,8 in order. Push of 1 into heap {5,3,8} takes busy_o for exactly 2 cycles.
- DEPTH=4: push 4 entries, then a fifth push -> err_o=01 for one cycle, count stays 4, full_o=1, top unchanged.
- Empty heap: pop -> err_o=10 for one cycle, empty_o=1. Replace prio 7 ctx 0xA0 -> count 1, top 7/0xA0, no error.
- Heap {2,4,6}: replace with prio 9 -> top becomes 4, count 3; subsequent pops give 4,6,9.
- FIFO_TIEBREAK_EN: push prio 3 with ctx 0x10, 0x20, 0x30 -> pops return 0x10, 0x20, 0x30. Preset the stamp counter near 0xFFFF and repeat to confirm wrap ordering.
- Push into 8-deep heap then assert flush_i during SIFT_UP -> next cycle count 0, busy_o 0, empty_o 1. Repeat with rst_i low mid-sift -> all outputs at reset values.
